readout_sequencer: RTL and testbench

READOUT_SEQUENCER -- requirements
Module: readout_sequencer

---
 rtl/readout_pkg.sv | 16 +
 rtl/readout_sequencer_group_counter.sv | 28 ++
 rtl/readout_sequencer.sv | 110 +++++++++++
 tb/tb_readout_sequencer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/readout_pkg.sv
// Shared types and group geometry for the pixel-array readout sequencer.
package readout_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_LO,
        ST_WR_HI,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // A group fills the 4-row buffer in two writes of two rows each.
    localparam int GROUP_ROWS     = 4;
    localparam int ROWS_PER_WRITE = 2;

endpackage

// File: rtl/readout_sequencer_group_counter.sv
// Group index counter for one frame: clears, increments and flags the last group.
module group_counter #(
    parameter int NUM_GROUPS = 2,
    parameter int CNT_W      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] count_reg;

    assign count = count_reg;
    assign last  = (count_reg == CNT_W'(NUM_GROUPS - 1));

    // Increment saturates at the last group so the index never wraps mid-frame.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (inc && !last) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/readout_sequencer.sv
// Row-pair readout sequencer filling a 4-row buffer per group, with a drain handshake.
// Optional abort input is enabled by defining READOUT_ABORT_EN.
module readout_sequencer #(
    parameter int NUM_ROWS = 8,
    parameter int ADDR_W   = $clog2(NUM_ROWS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              out_ready,
`ifdef READOUT_ABORT_EN
    input  logic              abort,
`endif
    output logic [ADDR_W-1:0] row_addr,
    output logic              buf_sel,
    output logic              buf_we,
    output logic              out_valid,
    output logic              busy,
    output logic              frame_done
);
    import readout_pkg::*;

    localparam int NUM_GROUPS = NUM_ROWS / GROUP_ROWS;
    localparam int CNT_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

    state_t            state_reg;
    logic [CNT_W-1:0]  g;
    logic              g_last;
    logic              g_clear;
    logic              g_inc;
    logic              abort_req;
    logic [ADDR_W-1:0] row_base;

`ifdef READOUT_ABORT_EN
    assign abort_req = abort && (state_reg != ST_IDLE);
`else
    assign abort_req = 1'b0;
`endif

    group_counter #(
        .NUM_GROUPS (NUM_GROUPS),
        .CNT_W      (CNT_W)
    ) u_group_counter (
        .clk   (clk),
        .reset (reset),
        .clear (g_clear),
        .inc   (g_inc),
        .count (g),
        .last  (g_last)
    );

    always_comb begin
        g_clear = 1'b0;
        g_inc   = 1'b0;
        if (abort_req) begin
            g_clear = 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE:  g_clear = start;
                ST_DRAIN: g_inc   = out_ready && !g_last;
                ST_DONE:  g_clear = 1'b1;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else if (abort_req) begin
            state_reg <= ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:  if (start) state_reg <= ST_WR_LO;
                ST_WR_LO: state_reg <= ST_WR_HI;
                ST_WR_HI: state_reg <= ST_DRAIN;
                ST_DRAIN: if (out_ready) state_reg <= g_last ? ST_DONE : ST_WR_LO;
                ST_DONE:  state_reg <= ST_IDLE;
                default:  state_reg <= ST_IDLE;
            endcase
        end
    end

    // Outputs depend only on registered state and group index.
    assign row_base = ADDR_W'(32'(g) * GROUP_ROWS);

    always_comb begin
        row_addr   = '0;
        buf_sel    = 1'b0;
        buf_we     = 1'b0;
        out_valid  = 1'b0;
        frame_done = 1'b0;
        busy       = (state_reg != ST_IDLE);
        case (state_reg)
            ST_WR_LO: begin
                buf_we   = 1'b1;
                row_addr = row_base;
            end
            ST_WR_HI: begin
                buf_we   = 1'b1;
                buf_sel  = 1'b1;
                row_addr = row_base + ADDR_W'(ROWS_PER_WRITE);
            end
            ST_DRAIN: out_valid  = 1'b1;
            ST_DONE:  frame_done = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_readout_sequencer.sv
// Directed-vector bench for readout_sequencer (NUM_ROWS=8 and NUM_ROWS=4 instances).
module tb_readout_sequencer;

    logic clk = 1'b0;
    logic reset, start, out_ready, abort;

    logic [2:0] addr8;
    logic       sel8, we8, ov8, busy8, fd8;
    logic [1:0] addr4;
    logic       sel4, we4, ov4, busy4, fd4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    readout_sequencer #(.NUM_ROWS(8)) dut8 (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .out_ready  (out_ready),
`ifdef READOUT_ABORT_EN
        .abort      (abort),
`endif
        .row_addr   (addr8),
        .buf_sel    (sel8),
        .buf_we     (we8),
        .out_valid  (ov8),
        .busy       (busy8),
        .frame_done (fd8)
    );

    readout_sequencer #(.NUM_ROWS(4)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .out_ready  (out_ready),
`ifdef READOUT_ABORT_EN
        .abort      (abort),
`endif
        .row_addr   (addr4),
        .buf_sel    (sel4),
        .buf_we     (we4),
        .out_valid  (ov4),
        .busy       (busy4),
        .frame_done (fd4)
    );

    // Observation word: {busy, frame_done, out_valid, buf_we, buf_sel, row_addr}
    typedef struct {
        logic       rst;
        logic       st;
        logic       rdy;
        logic       abt;
        logic       use4;
        logic [7:0] exp;
    } vec_t;

    vec_t vq[$];

    task automatic push(input logic rst, input logic st, input logic rdy,
                        input logic abt, input logic use4, input logic [7:0] exp);
        vec_t v;
        v.rst = rst; v.st = st; v.rdy = rdy; v.abt = abt; v.use4 = use4; v.exp = exp;
        vq.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        logic [7:0] got;

        // Reset state, both instances; reset beats start
        push(1, 0, 1, 0, 0, 8'h00);
        push(1, 0, 1, 0, 1, 8'h00);
        push(1, 1, 1, 0, 0, 8'h00);
        // Full frame with out_ready high
        push(0, 1, 1, 0, 0, 8'h90);
        push(0, 0, 1, 0, 0, 8'h9A);
        push(0, 0, 1, 0, 0, 8'hA0);
        push(0, 0, 1, 0, 0, 8'h94);
        push(0, 0, 1, 0, 0, 8'h9E);
        push(0, 0, 1, 0, 0, 8'hA0);
        push(0, 0, 1, 0, 0, 8'hC0);
        push(0, 0, 1, 0, 0, 8'h00);
        push(0, 0, 1, 0, 0, 8'h00);
        // out_ready low for five DRAIN cycles
        push(0, 1, 0, 0, 0, 8'h90);
        push(0, 0, 0, 0, 0, 8'h9A);
        for (int i = 0; i < 5; i++) push(0, 0, 0, 0, 0, 8'hA0);
        push(0, 0, 1, 0, 0, 8'h94);
        push(0, 0, 1, 0, 0, 8'h9E);
        push(0, 0, 1, 0, 0, 8'hA0);
        push(0, 0, 1, 0, 0, 8'hC0);
        push(0, 0, 1, 0, 0, 8'h00);
        // start re-pulsed in WR_HI and in DONE
        push(0, 1, 1, 0, 0, 8'h90);
        push(0, 0, 1, 0, 0, 8'h9A);
        push(0, 1, 1, 0, 0, 8'hA0);
        push(0, 0, 1, 0, 0, 8'h94);
        push(0, 0, 1, 0, 0, 8'h9E);
        push(0, 0, 1, 0, 0, 8'hA0);
        push(0, 0, 1, 0, 0, 8'hC0);
        push(0, 1, 1, 0, 0, 8'h00);
        push(0, 0, 1, 0, 0, 8'h00);
        // Reset in the second WR_LO, then restart from row 0
        push(0, 1, 1, 0, 0, 8'h90);
        push(0, 0, 1, 0, 0, 8'h9A);
        push(0, 0, 1, 0, 0, 8'hA0);
        push(0, 0, 1, 0, 0, 8'h94);
        push(1, 0, 1, 0, 0, 8'h00);
        push(0, 0, 1, 0, 0, 8'h00);
        push(0, 1, 1, 0, 0, 8'h90);
        push(0, 0, 1, 0, 0, 8'h9A);
        push(0, 0, 1, 0, 0, 8'hA0);
        push(0, 0, 1, 0, 0, 8'h94);
        push(0, 0, 1, 0, 0, 8'h9E);
        push(0, 0, 1, 0, 0, 8'hA0);
        push(0, 0, 1, 0, 0, 8'hC0);
        push(0, 0, 1, 0, 0, 8'h00);
`ifdef READOUT_ABORT_EN
        // Abort wins over out_ready in DRAIN; next frame restarts at group 0
        push(0, 1, 1, 0, 0, 8'h90);
        push(0, 0, 1, 0, 0, 8'h9A);
        push(0, 0, 1, 0, 0, 8'hA0);
        push(0, 0, 1, 1, 0, 8'h00);
        push(0, 0, 1, 0, 0, 8'h00);
        push(0, 1, 1, 0, 0, 8'h90);
        push(0, 0, 1, 0, 0, 8'h9A);
        push(0, 0, 1, 0, 0, 8'hA0);
        push(0, 0, 1, 0, 0, 8'h94);
`endif
        // Single-group array (NUM_ROWS=4)
        push(1, 0, 1, 0, 1, 8'h00);
        push(0, 1, 1, 0, 1, 8'h48);
        push(0, 0, 1, 0, 1, 8'h4E);
        push(0, 0, 1, 0, 1, 8'h50);
        push(0, 0, 1, 0, 1, 8'h60);
        push(0, 0, 1, 0, 1, 8'h00);

        reset = 1'b1; start = 1'b0; out_ready = 1'b1; abort = 1'b0;
        @(posedge clk); #1;

        foreach (vq[i]) begin
            reset     = vq[i].rst;
            start     = vq[i].st;
            out_ready = vq[i].rdy;
            abort     = vq[i].abt;
            @(posedge clk); #1;
            if (vq[i].use4)
                got = {1'b0, busy4, fd4, ov4, we4, sel4, addr4};
            else
                got = {busy8, fd8, ov8, we8, sel8, addr8};
            $display("vec %0d dut%0d rst=%b start=%b ready=%b abort=%b obs=%h exp=%h",
                     i, vq[i].use4 ? 4 : 8, vq[i].rst, vq[i].st, vq[i].rdy, vq[i].abt,
                     got, vq[i].exp);
            check($sformatf("vec%0d", i), 32'(got), 32'(vq[i].exp));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
